lsu_mem_if: RTL and testbench

//  Load/store unit. Takes the effective address from the EX-stage ALU add path (rs1+imm)
//  and acts as the requester on the single-outstanding data-memory req/rsp interface.

---
 rtl/lsu_mem_if_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 74 +++++++
 rtl/lsu_mem_if.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_if.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_if_pkg.sv
// -----------------------------------------------------------------------------
// lsu_mem_if_pkg
//   Shared definitions for the load/store unit:
//   - lsu_size_e        : access size encoding (B/H/W/D)
//   - lsu_state_e       : request FSM state encoding
//   - CAUSE_*           : misalignment exception cause codes
//   - size_low_mask()   : address bits that must be zero for a naturally
//                         aligned access of the given size
//   - is_misaligned()   : true when the byte offset violates that alignment
// -----------------------------------------------------------------------------
package lsu_mem_if_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_e;

   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

   // Low address bits covered by an access of this size (bytes-1).
   function automatic logic [2:0] size_low_mask(input lsu_size_e size);
      case (size)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] off);
      return (off & size_low_mask(size)) != 3'b000;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Combinational data path of the load/store unit.
//   Store side: replicates the store operand across all lanes of the bus and
//   generates byte strobes for the addressed lanes (strobes are zero for loads).
//   Load side: shifts the addressed bytes of the returned dword down to bit 0,
//   truncates to the access size and sign- or zero-extends.
// Ports
//   i_size        access size (lsu_size_e encoding)
//   i_off         byte offset within the aligned dword
//   i_unsigned    zero-extend loads
//   i_is_store    op is a store (enables strobes)
//   i_store_data  store operand (rs2)
//   i_rdata       whole aligned dword from memory
//   o_wdata       lane-replicated store data
//   o_wstrb       byte strobes
//   o_ldata       extracted and extended load result
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_mem_if_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [1:0]        i_size,
   input  logic [2:0]        i_off,
   input  logic              i_unsigned,
   input  logic              i_is_store,
   input  logic [XLEN-1:0]   i_store_data,
   input  logic [XLEN-1:0]   i_rdata,
   output logic [XLEN-1:0]   o_wdata,
   output logic [XLEN/8-1:0] o_wstrb,
   output logic [XLEN-1:0]   o_ldata
);

   localparam int STRBW = XLEN / 8;

   lsu_size_e        w_size;
   logic [STRBW-1:0] w_mask;
   logic [XLEN-1:0]  w_shifted;
   logic             w_sext;

   assign w_size    = lsu_size_e'(i_size);
   assign w_shifted = i_rdata >> {i_off, 3'b000};
   assign w_sext    = ~i_unsigned;

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a value unassigned; otherwise synthesis infers a latch.
      o_wdata = i_store_data;
      w_mask  = '1;
      o_ldata = w_shifted;
      case (w_size)
         SZ_B: begin
            o_wdata = {(XLEN/8){i_store_data[7:0]}};
            w_mask  = STRBW'(8'h01);
            o_ldata = {{(XLEN-8){w_sext & w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_H: begin
            o_wdata = {(XLEN/16){i_store_data[15:0]}};
            w_mask  = STRBW'(8'h03);
            o_ldata = {{(XLEN-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
         end
         SZ_W: begin
            o_wdata = {(XLEN/32){i_store_data[31:0]}};
            w_mask  = STRBW'(8'h0F);
            o_ldata = {{(XLEN-32){w_sext & w_shifted[31]}}, w_shifted[31:0]};
         end
         default: ;  // SZ_D: full-width data, all strobes, no extension
      endcase
   end

   assign o_wstrb = i_is_store ? (w_mask << i_off) : '0;

endmodule

// File: rtl/lsu_mem_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_if
//   Load/store unit. Accepts one memory op from EX, issues it on a single-
//   outstanding req/rsp data-memory interface, and returns load results to
//   writeback as a one-cycle pulse. EX is held (ex_ready_o=0) while busy.
//   FSM: IDLE -> REQ -> WAIT -> IDLE.
// Configuration macro
//   LSU_MISALIGN_TRAP_EN : misaligned ops raise a one-cycle exception pulse
//                          instead of issuing a request. When undefined the
//                          address is aligned down to the access size and
//                          exc_* are tied to 0.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   ex_valid_i / ex_ready_o         EX handshake (ready only in IDLE)
//   ex_load_i, ex_store_i           op kind (both set -> store, none -> dropped)
//   ex_size_i, ex_unsigned_i        access size, zero-extend loads
//   ex_rd_i, ex_addr_i, ex_wdata_i  destination, effective address, store data
//   mem_req_*                       request channel (fields held from registers)
//   mem_rsp_valid_i, mem_rsp_rdata_i response/ack channel
//   wb_valid_o, wb_rd_o, wb_data_o  load result pulse
//   exc_valid_o, exc_cause_o, exc_tval_o  misalignment trap pulse
// -----------------------------------------------------------------------------
module lsu_mem_if
   import lsu_mem_if_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic              ex_load_i,
   input  logic              ex_store_i,
   input  logic [1:0]        ex_size_i,
   input  logic              ex_unsigned_i,
   input  logic [4:0]        ex_rd_i,
   input  logic [XLEN-1:0]   ex_addr_i,
   input  logic [XLEN-1:0]   ex_wdata_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic              mem_req_we_o,
   output logic [XLEN-1:0]   mem_req_addr_o,
   output logic [XLEN-1:0]   mem_req_wdata_o,
   output logic [XLEN/8-1:0] mem_req_wstrb_o,
   input  logic              mem_rsp_valid_i,
   input  logic [XLEN-1:0]   mem_rsp_rdata_i,
   output logic              wb_valid_o,
   output logic [4:0]        wb_rd_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              exc_valid_o,
   output logic [3:0]        exc_cause_o,
   output logic [XLEN-1:0]   exc_tval_o
);

   lsu_state_e      r_state;
   logic            r_we;
   lsu_size_e       r_size;
   logic            r_unsigned;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic            r_wb_valid;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_data;

   lsu_size_e       w_size;
   logic            w_accept;
   logic [XLEN-1:0] w_ldata;

   assign w_size   = lsu_size_e'(ex_size_i);
   // Ops with neither load nor store set are consumed and dropped.
   assign w_accept = ex_valid_i & (r_state == ST_IDLE) & (ex_load_i | ex_store_i);

`ifdef LSU_MISALIGN_TRAP_EN
   logic            w_misal;
   logic            r_exc_valid;
   logic [3:0]      r_exc_cause;
   logic [XLEN-1:0] r_exc_tval;

   assign w_misal = is_misaligned(w_size, ex_addr_i[2:0]);
`else
   logic [XLEN-1:0] w_addr_aligned;

   assign w_addr_aligned = ex_addr_i & ~{{(XLEN-3){1'b0}}, size_low_mask(w_size)};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_we        <= 1'b0;
         r_size      <= SZ_B;
         r_unsigned  <= 1'b0;
         r_rd        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_data   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_exc_valid <= 1'b0;
         r_exc_cause <= '0;
         r_exc_tval  <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every register samples
         // pre-edge values regardless of statement order.
         r_wb_valid  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_exc_valid <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we       <= ex_store_i;  // store wins when both are set
                  r_size     <= w_size;
                  r_unsigned <= ex_unsigned_i;
                  r_rd       <= ex_rd_i;
                  r_wdata    <= ex_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
                  r_addr     <= ex_addr_i;
                  if (w_misal) begin
                     r_exc_valid <= 1'b1;
                     r_exc_cause <= ex_store_i ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
                     r_exc_tval  <= ex_addr_i;
                  end else begin
                     r_state <= ST_REQ;
                  end
`else
                  r_addr     <= w_addr_aligned;
                  r_state    <= ST_REQ;
`endif
               end
            end
            ST_REQ: begin
               if (mem_req_ready_i) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_rsp_valid_i) begin
                  r_state <= ST_IDLE;
                  if (!r_we) begin
                     r_wb_valid <= 1'b1;
                     r_wb_rd    <= r_rd;
                     r_wb_data  <= w_ldata;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_size       (r_size),
      .i_off        (r_addr[2:0]),
      .i_unsigned   (r_unsigned),
      .i_is_store   (r_we),
      .i_store_data (r_wdata),
      .i_rdata      (mem_rsp_rdata_i),
      .o_wdata      (mem_req_wdata_o),
      .o_wstrb      (mem_req_wstrb_o),
      .o_ldata      (w_ldata)
   );

   assign ex_ready_o      = (r_state == ST_IDLE);
   assign mem_req_valid_o = (r_state == ST_REQ);
   assign mem_req_we_o    = r_we;
   assign mem_req_addr_o  = {r_addr[XLEN-1:3], 3'b000};
   assign wb_valid_o      = r_wb_valid;
   assign wb_rd_o         = r_wb_rd;
   assign wb_data_o       = r_wb_data;

`ifdef LSU_MISALIGN_TRAP_EN
   assign exc_valid_o = r_exc_valid;
   assign exc_cause_o = r_exc_cause;
   assign exc_tval_o  = r_exc_tval;
`else
   assign exc_valid_o = 1'b0;
   assign exc_cause_o = '0;
   assign exc_tval_o  = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_if.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_if
//   Directed self-checking bench for lsu_mem_if. Inputs change on the falling
//   edge; outputs are sampled on the falling edge, half a cycle after the
//   rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_lsu_mem_if;
   import lsu_mem_if_pkg::*;

   localparam int XLEN = 64;

   logic              clk;
   logic              rst_n;
   logic              ex_valid_i;
   logic              ex_ready_o;
   logic              ex_load_i;
   logic              ex_store_i;
   logic [1:0]        ex_size_i;
   logic              ex_unsigned_i;
   logic [4:0]        ex_rd_i;
   logic [XLEN-1:0]   ex_addr_i;
   logic [XLEN-1:0]   ex_wdata_i;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic              mem_req_we_o;
   logic [XLEN-1:0]   mem_req_addr_o;
   logic [XLEN-1:0]   mem_req_wdata_o;
   logic [XLEN/8-1:0] mem_req_wstrb_o;
   logic              mem_rsp_valid_i;
   logic [XLEN-1:0]   mem_rsp_rdata_i;
   logic              wb_valid_o;
   logic [4:0]        wb_rd_o;
   logic [XLEN-1:0]   wb_data_o;
   logic              exc_valid_o;
   logic [3:0]        exc_cause_o;
   logic [XLEN-1:0]   exc_tval_o;

   int n_cmp = 0;
   int n_err = 0;

   lsu_mem_if #(.XLEN(XLEN)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ex_valid_i      (ex_valid_i),
      .ex_ready_o      (ex_ready_o),
      .ex_load_i       (ex_load_i),
      .ex_store_i      (ex_store_i),
      .ex_size_i       (ex_size_i),
      .ex_unsigned_i   (ex_unsigned_i),
      .ex_rd_i         (ex_rd_i),
      .ex_addr_i       (ex_addr_i),
      .ex_wdata_i      (ex_wdata_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_we_o    (mem_req_we_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_wdata_o (mem_req_wdata_o),
      .mem_req_wstrb_o (mem_req_wstrb_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_rdata_i (mem_rsp_rdata_i),
      .wb_valid_o      (wb_valid_o),
      .wb_rd_o         (wb_rd_o),
      .wb_data_o       (wb_data_o),
      .exc_valid_o     (exc_valid_o),
      .exc_cause_o     (exc_cause_o),
      .exc_tval_o      (exc_tval_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running exp finished");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [4:0] rd,
                        input logic [63:0] a, input logic [63:0] d);
      ex_valid_i = 1'b1; ex_load_i = ld; ex_store_i = st; ex_size_i = sz;
      ex_unsigned_i = uns; ex_rd_i = rd; ex_addr_i = a; ex_wdata_i = d;
      @(negedge clk);
      ex_valid_i = 1'b0; ex_load_i = 1'b0; ex_store_i = 1'b0;
   endtask

   task automatic req_handshake(input logic rsp_same_cycle);
      mem_req_ready_i = 1'b1; mem_rsp_valid_i = rsp_same_cycle;
      @(negedge clk);
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
   endtask

   task automatic respond(input logic [63:0] rdata);
      mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = rdata;
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      ex_valid_i = 0; ex_load_i = 0; ex_store_i = 0; ex_size_i = 0; ex_unsigned_i = 0;
      ex_rd_i = 0; ex_addr_i = 0; ex_wdata_i = 0;
      mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_rdata_i = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL reset.ex_ready got %b exp 1", ex_ready_o); end
      n_cmp++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL reset.req_valid got %b exp 0", mem_req_valid_o); end
      n_cmp++; if (mem_req_we_o !== 1'b0) begin n_err++; $display("FAIL reset.req_we got %b exp 0", mem_req_we_o); end
      n_cmp++; if (mem_req_addr_o !== 64'h0) begin n_err++; $display("FAIL reset.req_addr got %h exp 0", mem_req_addr_o); end
      n_cmp++; if (mem_req_wstrb_o !== 8'h00) begin n_err++; $display("FAIL reset.wstrb got %h exp 00", mem_req_wstrb_o); end
      n_cmp++; if (mem_req_wdata_o !== 64'h0) begin n_err++; $display("FAIL reset.wdata got %h exp 0", mem_req_wdata_o); end
      n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL reset.wb_valid got %b exp 0", wb_valid_o); end
      n_cmp++; if (wb_data_o !== 64'h0) begin n_err++; $display("FAIL reset.wb_data got %h exp 0", wb_data_o); end
      n_cmp++; if (exc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset.exc_valid got %b exp 0", exc_valid_o); end
   endtask

   task automatic test_store_dword;
      issue(1'b0, 1'b1, 2'd3, 1'b0, 5'd0, 64'h1000, 64'h1122334455667788);
      n_cmp++; if (mem_req_valid_o !== 1'b1) begin n_err++; $display("FAIL sd.req_valid got %b exp 1", mem_req_valid_o); end
      n_cmp++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL sd.ex_ready_busy got %b exp 0", ex_ready_o); end
      n_cmp++; if (mem_req_we_o !== 1'b1) begin n_err++; $display("FAIL sd.we got %b exp 1", mem_req_we_o); end
      n_cmp++; if (mem_req_addr_o !== 64'h1000) begin n_err++; $display("FAIL sd.addr got %h exp 1000", mem_req_addr_o); end
      n_cmp++; if (mem_req_wdata_o !== 64'h1122334455667788) begin n_err++; $display("FAIL sd.wdata got %h exp 1122334455667788", mem_req_wdata_o); end
      n_cmp++; if (mem_req_wstrb_o !== 8'hFF) begin n_err++; $display("FAIL sd.wstrb got %h exp ff", mem_req_wstrb_o); end
      req_handshake(1'b0);
      n_cmp++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL sd.req_valid_wait got %b exp 0", mem_req_valid_o); end
      respond(64'h0);
      n_cmp++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL sd.ex_ready_done got %b exp 1", ex_ready_o); end
      n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL sd.no_wb got %b exp 0", wb_valid_o); end
   endtask

   task automatic test_store_byte;
      issue(1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 64'h1003, 64'h123456789ABCDEAB);
      n_cmp++; if (mem_req_wdata_o !== 64'hABABABABABABABAB) begin n_err++; $display("FAIL sb.wdata got %h exp abababababababab", mem_req_wdata_o); end
      n_cmp++; if (mem_req_wstrb_o !== 8'h08) begin n_err++; $display("FAIL sb.wstrb got %h exp 08", mem_req_wstrb_o); end
      n_cmp++; if (mem_req_addr_o !== 64'h1000) begin n_err++; $display("FAIL sb.addr got %h exp 1000", mem_req_addr_o); end
      // Response in the handshake cycle must be ignored: still waiting afterwards.
      req_handshake(1'b1);
      n_cmp++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL sb.rsp_in_req_ignored got ready %b exp 0", ex_ready_o); end
      respond(64'h0);
      n_cmp++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL sb.ex_ready_done got %b exp 1", ex_ready_o); end
   endtask

   task automatic test_load_byte;
      issue(1'b1, 1'b0, 2'd0, 1'b0, 5'd9, 64'h2005, 64'h0);
      n_cmp++; if (mem_req_we_o !== 1'b0) begin n_err++; $display("FAIL lb.we got %b exp 0", mem_req_we_o); end
      n_cmp++; if (mem_req_wstrb_o !== 8'h00) begin n_err++; $display("FAIL lb.wstrb got %h exp 00", mem_req_wstrb_o); end
      n_cmp++; if (mem_req_addr_o !== 64'h2000) begin n_err++; $display("FAIL lb.addr got %h exp 2000", mem_req_addr_o); end
      req_handshake(1'b0);
      respond(64'h000080FF00000000);
      n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL lb.wb_valid got %b exp 1", wb_valid_o); end
      n_cmp++; if (wb_data_o !== 64'hFFFFFFFFFFFFFF80) begin n_err++; $display("FAIL lb.wb_data got %h exp ffffffffffffff80", wb_data_o); end
      n_cmp++; if (wb_rd_o !== 5'd9) begin n_err++; $display("FAIL lb.wb_rd got %0d exp 9", wb_rd_o); end
      @(negedge clk);
      n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL lb.wb_pulse_one_cycle got %b exp 0", wb_valid_o); end
      // Unsigned variant.
      issue(1'b1, 1'b0, 2'd0, 1'b1, 5'd10, 64'h2005, 64'h0);
      req_handshake(1'b0);
      respond(64'h000080FF00000000);
      n_cmp++; if (wb_data_o !== 64'h0000000000000080) begin n_err++; $display("FAIL lbu.wb_data got %h exp 80", wb_data_o); end
      n_cmp++; if (wb_rd_o !== 5'd10) begin n_err++; $display("FAIL lbu.wb_rd got %0d exp 10", wb_rd_o); end
   endtask

   task automatic test_load_word_stall;
      issue(1'b1, 1'b0, 2'd2, 1'b0, 5'd4, 64'h3004, 64'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 64'h3000 || mem_req_wstrb_o !== 8'h00 || mem_req_we_o !== 1'b0) begin
            n_err++; $display("FAIL lw.stall_stable[%0d] got v=%b a=%h s=%h we=%b exp v=1 a=3000 s=00 we=0",
                              i, mem_req_valid_o, mem_req_addr_o, mem_req_wstrb_o, mem_req_we_o);
         end
      end
      req_handshake(1'b0);
      @(negedge clk);
      n_cmp++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b0) begin n_err++; $display("FAIL lw.wait_idle got wb=%b rdy=%b exp wb=0 rdy=0", wb_valid_o, ex_ready_o); end
      respond(64'h8765432100000000);
      n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL lw.wb_valid got %b exp 1", wb_valid_o); end
      n_cmp++; if (wb_data_o !== 64'hFFFFFFFF87654321) begin n_err++; $display("FAIL lw.wb_data got %h exp ffffffff87654321", wb_data_o); end
      n_cmp++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL lw.ex_ready got %b exp 1", ex_ready_o); end
      // LWU and LD on the same dword.
      issue(1'b1, 1'b0, 2'd2, 1'b1, 5'd5, 64'h3004, 64'h0);
      req_handshake(1'b0);
      respond(64'h8765432100000000);
      n_cmp++; if (wb_data_o !== 64'h0000000087654321) begin n_err++; $display("FAIL lwu.wb_data got %h exp 87654321", wb_data_o); end
      issue(1'b1, 1'b0, 2'd3, 1'b0, 5'd6, 64'h3008, 64'h0);
      req_handshake(1'b0);
      respond(64'hF0E1D2C3B4A59687);
      n_cmp++; if (wb_data_o !== 64'hF0E1D2C3B4A59687) begin n_err++; $display("FAIL ld.wb_data got %h exp f0e1d2c3b4a59687", wb_data_o); end
      issue(1'b1, 1'b0, 2'd1, 1'b0, 5'd7, 64'h5006, 64'h0);
      req_handshake(1'b0);
      respond(64'h7FFE000000008000);
      n_cmp++; if (wb_data_o !== 64'h0000000000007FFE) begin n_err++; $display("FAIL lh.wb_data got %h exp 7ffe", wb_data_o); end
   endtask

   task automatic test_drop_and_both;
      // Neither load nor store: dropped.
      issue(1'b0, 1'b0, 2'd3, 1'b0, 5'd1, 64'h7000, 64'h0);
      n_cmp++; if (ex_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL drop.idle got rdy=%b v=%b exp rdy=1 v=0", ex_ready_o, mem_req_valid_o); end
      // Response while idle is ignored.
      respond(64'hFFFFFFFFFFFFFFFF);
      n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL drop.rsp_idle_ignored got %b exp 0", wb_valid_o); end
      // Both load and store: treated as a store.
      issue(1'b1, 1'b1, 2'd1, 1'b0, 5'd2, 64'h7002, 64'h000000000000BEEF);
      n_cmp++; if (mem_req_we_o !== 1'b1) begin n_err++; $display("FAIL both.we got %b exp 1", mem_req_we_o); end
      n_cmp++; if (mem_req_wstrb_o !== 8'h0C) begin n_err++; $display("FAIL both.wstrb got %h exp 0c", mem_req_wstrb_o); end
      n_cmp++; if (mem_req_wdata_o !== 64'hBEEFBEEFBEEFBEEF) begin n_err++; $display("FAIL both.wdata got %h exp beefbeefbeefbeef", mem_req_wdata_o); end
      req_handshake(1'b0);
      respond(64'h0);
      n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL both.no_wb got %b exp 0", wb_valid_o); end
   endtask

   task automatic test_misaligned;
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b1, 1'b0, 2'd1, 1'b0, 5'd3, 64'h4001, 64'h0);
      n_cmp++; if (exc_valid_o !== 1'b1) begin n_err++; $display("FAIL mis_lh.exc_valid got %b exp 1", exc_valid_o); end
      n_cmp++; if (exc_cause_o !== 4'd4) begin n_err++; $display("FAIL mis_lh.cause got %0d exp 4", exc_cause_o); end
      n_cmp++; if (exc_tval_o !== 64'h4001) begin n_err++; $display("FAIL mis_lh.tval got %h exp 4001", exc_tval_o); end
      n_cmp++; if (mem_req_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin n_err++; $display("FAIL mis_lh.no_req got v=%b rdy=%b exp v=0 rdy=1", mem_req_valid_o, ex_ready_o); end
      @(negedge clk);
      n_cmp++; if (exc_valid_o !== 1'b0 || wb_valid_o !== 1'b0) begin n_err++; $display("FAIL mis_lh.pulse got exc=%b wb=%b exp 0 0", exc_valid_o, wb_valid_o); end
      issue(1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 64'h4006, 64'h00000000CAFEF00D);
      n_cmp++; if (exc_valid_o !== 1'b1 || exc_cause_o !== 4'd6 || exc_tval_o !== 64'h4006) begin
         n_err++; $display("FAIL mis_sw.exc got v=%b c=%0d t=%h exp v=1 c=6 t=4006", exc_valid_o, exc_cause_o, exc_tval_o);
      end
      n_cmp++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL mis_sw.no_req got %b exp 0", mem_req_valid_o); end
      @(negedge clk);
`else
      issue(1'b1, 1'b0, 2'd1, 1'b0, 5'd3, 64'h4001, 64'h0);
      n_cmp++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 64'h4000) begin n_err++; $display("FAIL mis_lh.req got v=%b a=%h exp v=1 a=4000", mem_req_valid_o, mem_req_addr_o); end
      req_handshake(1'b0);
      respond(64'h000000000000F234);
      n_cmp++; if (wb_data_o !== 64'hFFFFFFFFFFFFF234) begin n_err++; $display("FAIL mis_lh.wb_data got %h exp fffffffffffff234", wb_data_o); end
      n_cmp++; if (exc_valid_o !== 1'b0) begin n_err++; $display("FAIL mis_lh.exc got %b exp 0", exc_valid_o); end
      issue(1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 64'h4006, 64'h00000000CAFEF00D);
      n_cmp++; if (mem_req_addr_o !== 64'h4000) begin n_err++; $display("FAIL mis_sw.addr got %h exp 4000", mem_req_addr_o); end
      n_cmp++; if (mem_req_wstrb_o !== 8'hF0) begin n_err++; $display("FAIL mis_sw.wstrb got %h exp f0", mem_req_wstrb_o); end
      n_cmp++; if (mem_req_wdata_o !== 64'hCAFEF00DCAFEF00D) begin n_err++; $display("FAIL mis_sw.wdata got %h exp cafef00dcafef00d", mem_req_wdata_o); end
      req_handshake(1'b0);
      respond(64'h0);
`endif
   endtask

   task automatic test_reset_mid_op;
      issue(1'b1, 1'b0, 2'd3, 1'b0, 5'd7, 64'h6000, 64'h0);
      req_handshake(1'b0);
      n_cmp++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_mid.in_wait got rdy=%b exp 0", ex_ready_o); end
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (ex_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || wb_valid_o !== 1'b0) begin
         n_err++; $display("FAIL rst_mid.idle got rdy=%b v=%b wb=%b exp 1 0 0", ex_ready_o, mem_req_valid_o, wb_valid_o);
      end
      n_cmp++; if (mem_req_addr_o !== 64'h0) begin n_err++; $display("FAIL rst_mid.regs_cleared got %h exp 0", mem_req_addr_o); end
      @(negedge clk);
      n_cmp++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_mid.after got wb=%b rdy=%b exp 0 1", wb_valid_o, ex_ready_o); end
   endtask

   initial begin
      test_reset();
      test_store_dword();
      test_store_byte();
      test_load_byte();
      test_load_word_stall();
      test_drop_and_both();
      test_misaligned();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
